// File: rtl/lf_dac.sv
// Dual-channel 12-bit serial DAC writer: streams a channel-A and a channel-B frame, then
// strobes nLDAC so both analogue outputs update together.
module lf_dac #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAIN_A  = 1,
    parameter int unsigned GAIN_B  = 1
) (
    input  logic        clock,
    input  logic        nRST,
    input  logic [11:0] AOUT1,
    input  logic [11:0] AOUT2,
    input  logic        update_req,
    output logic        SCLK,
    output logic        nCS,
    output logic        MOSI,
    output logic        nLDAC,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle, StCapture, StFrameA, StGapA, StFrameB, StGapB, StLdac, StDone
    } state_e;

    typedef enum logic [1:0] {PhSetup, PhHigh, PhLow} phase_e;

    localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);
    localparam logic       GaA      = 1'(GAIN_A);
    localparam logic       GaB      = 1'(GAIN_B);

    function automatic logic [15:0] frame_word(input logic ch, input logic ga,
                                               input logic [11:0] code);
        return {ch, 1'b0, ga, 1'b1, code};
    endfunction

    // Assertion passes straight through; release is delayed by two clocks.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  half_q, half_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] shadow_a_q, shadow_a_d;
    logic [11:0] shadow_b_q, shadow_b_d;
    logic        req_f_q, req_f_d;

    logic half_last, pending, in_frame;

    assign half_last = (half_q == HalfLast);
    assign pending   = (AOUT1 != shadow_a_q) || (AOUT2 != shadow_b_q) || req_f_q;
    assign in_frame  = (state_q == StFrameA) || (state_q == StFrameB);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= PhSetup;
            half_q     <= 8'd0;
            bit_q      <= 4'd0;
            shift_q    <= 16'd0;
            shadow_a_q <= 12'd0;
            shadow_b_q <= 12'd0;
            req_f_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            req_f_q    <= req_f_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        half_d     = half_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        req_f_d    = req_f_q | update_req;

        unique case (state_q)
            StIdle: begin
                if (pending) state_d = StCapture;
            end
            StCapture: begin
                shadow_a_d = AOUT1;
                shadow_b_d = AOUT2;
                // A request arriving in this very cycle must survive the clear.
                req_f_d    = update_req;
                shift_d    = frame_word(1'b0, GaA, AOUT1);
                half_d     = 8'd0;
                bit_d      = 4'd0;
                phase_d    = PhSetup;
                state_d    = StFrameA;
            end
            StFrameA, StFrameB: begin
                half_d = half_last ? 8'd0 : half_q + 8'd1;
                if (half_last) begin
                    unique case (phase_q)
                        PhSetup: phase_d = PhHigh;
                        PhHigh: begin
                            // Falling SCLK edge: advance to the next bit, zero-filling.
                            phase_d = PhLow;
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                        PhLow: begin
                            if (bit_q == 4'd15) begin
                                bit_d   = 4'd0;
                                phase_d = PhSetup;
                                state_d = (state_q == StFrameA) ? StGapA : StGapB;
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                phase_d = PhHigh;
                            end
                        end
                        default: phase_d = PhSetup;
                    endcase
                end
            end
            StGapA: begin
                half_d = half_last ? 8'd0 : half_q + 8'd1;
                if (half_last) begin
                    shift_d = frame_word(1'b1, GaB, shadow_b_q);
                    state_d = StFrameB;
                end
            end
            StGapB: begin
                half_d = half_last ? 8'd0 : half_q + 8'd1;
                if (half_last) state_d = StLdac;
            end
            StLdac: begin
                half_d = half_last ? 8'd0 : half_q + 8'd1;
                if (half_last) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign nCS   = !in_frame;
    assign SCLK  = in_frame && (phase_q == PhHigh);
    assign MOSI  = in_frame && shift_q[15];
    assign nLDAC = (state_q != StLdac);
    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_lf_dac.sv
// Scoreboard bench for lf_dac: two instances (CLK_DIV=2 default gains; CLK_DIV=1 with GAIN_B=0)
// share stimulus; a reference model predicts frames and sequence counts per instance.
module tb_lf_dac;

    logic        clock = 1'b0;
    logic        nRST = 1'b0;
    logic [11:0] AOUT1 = 12'd0;
    logic [11:0] AOUT2 = 12'd0;
    logic        update_req = 1'b0;
    logic [1:0]  sclk, ncs, mosi, nldac, busy, done;

    lf_dac #(.CLK_DIV(2), .GAIN_A(1), .GAIN_B(1)) u_dac0 (
        .clock(clock), .nRST(nRST), .AOUT1(AOUT1), .AOUT2(AOUT2), .update_req(update_req),
        .SCLK(sclk[0]), .nCS(ncs[0]), .MOSI(mosi[0]), .nLDAC(nldac[0]),
        .busy(busy[0]), .done(done[0])
    );

    lf_dac #(.CLK_DIV(1), .GAIN_A(1), .GAIN_B(0)) u_dac1 (
        .clock(clock), .nRST(nRST), .AOUT1(AOUT1), .AOUT2(AOUT2), .update_req(update_req),
        .SCLK(sclk[1]), .nCS(ncs[1]), .MOSI(mosi[1]), .nLDAC(nldac[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int id, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    function automatic int div_of(input int id);
        return (id == 0) ? 2 : 1;
    endfunction

    function automatic logic gb_of(input int id);
        return (id == 0);
    endfunction

    // Reference model state, per instance.
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int          m_mode[2];
    int          m_left[2];
    int          m_sync[2];
    int          m_seq[2];
    logic [11:0] m_sha[2];
    logic [11:0] m_shb[2];
    logic        m_req[2];
    int          done_cnt[2];
    int          ldac_cnt[2];

    function automatic bit m_pending(input int id);
        return (AOUT1 != m_sha[id]) || (AOUT2 != m_shb[id]) || m_req[id];
    endfunction

    function automatic bit quiet(input int id);
        return (m_sync[id] == 2) && (m_mode[id] == 0) && !m_pending(id);
    endfunction

    function automatic void push_exp(input int id, input logic [15:0] w);
        if (id == 0) exp_q0.push_back(w);
        else         exp_q1.push_back(w);
    endfunction

    // Model: idle -> capture -> fixed-length sequence of 1 + 69*div cycles after capture.
    task automatic model(input int id);
        int d = div_of(id);
        forever begin
            @(posedge clock);
            if (!nRST) begin
                m_sha[id] = 12'd0; m_shb[id] = 12'd0; m_req[id] = 1'b1;
                m_mode[id] = 0; m_sync[id] = 0;
                if (id == 0) exp_q0.delete();
                else         exp_q1.delete();
            end else if (m_sync[id] < 2) begin
                m_sync[id]++;
            end else begin
                case (m_mode[id])
                    0: begin
                        if (m_pending(id)) m_mode[id] = 1;
                        m_req[id] = m_req[id] | update_req;
                    end
                    1: begin
                        m_sha[id] = AOUT1;
                        m_shb[id] = AOUT2;
                        m_req[id] = update_req;
                        push_exp(id, {1'b0, 1'b0, 1'b1, 1'b1, AOUT1});
                        push_exp(id, {1'b1, 1'b0, gb_of(id), 1'b1, AOUT2});
                        m_left[id] = 69 * d + 1;
                        m_mode[id] = 2;
                    end
                    default: begin
                        m_req[id] = m_req[id] | update_req;
                        m_left[id]--;
                        if (m_left[id] == 0) begin
                            m_mode[id] = 0;
                            m_seq[id]++;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic monitor(input int id);
        int          d = div_of(id);
        logic        p_sclk = 1'b0, p_ncs = 1'b1, p_nldac = 1'b1, p_busy = 1'b0;
        logic        act = 1'b0;
        logic [15:0] bits = 16'd0;
        logic [15:0] e;
        int          nbits = 0, ncs_len = 0, hi_len = 0, ldac_len = 0;
        int unsigned cap = 0;
        forever begin
            @(negedge clock);
            if (!nRST) begin
                act = 1'b0; ldac_len = 0;
                p_sclk = 1'b0; p_ncs = 1'b1; p_nldac = 1'b1; p_busy = 1'b0;
                continue;
            end
            if (!ncs[id]) begin
                if (p_ncs) begin
                    act = 1'b1; bits = 16'd0; nbits = 0; ncs_len = 0; hi_len = 0;
                end
                ncs_len++;
                if (sclk[id]) hi_len++;
                if (sclk[id] && !p_sclk) begin
                    bits = {bits[14:0], mosi[id]};
                    nbits++;
                end
            end else begin
                check("idle_sclk_mosi", id, int'({sclk[id], mosi[id]}), 0);
                if (!p_ncs && act) begin
                    act = 1'b0;
                    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                        n_cmp++; n_err++;
                        $display("FAIL frame[dut%0d]: got 0x%04h, expected no frame", id, bits);
                    end else begin
                        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("frame", id, int'(bits), int'(e));
                        check("ncs_low_len", id, ncs_len, 33 * d);
                        check("sclk_high_len", id, hi_len, 16 * d);
                        check("bit_count", id, nbits, 16);
                    end
                end
            end
            if (!nldac[id]) begin
                ldac_len++;
                check("ldac_lines", id, int'({ncs[id], sclk[id]}), 2);
            end else if (!p_nldac) begin
                check("ldac_len", id, ldac_len, d);
                ldac_cnt[id]++;
                ldac_len = 0;
            end
            if (busy[id] && !p_busy) cap = cyc;
            if (done[id]) begin
                check("latency", id, int'(cyc - cap), 1 + 69 * d);
                check("busy_in_done", id, int'(busy[id]), 0);
                done_cnt[id]++;
            end
            p_sclk = sclk[id]; p_ncs = ncs[id]; p_nldac = nldac[id]; p_busy = busy[id];
        end
    endtask

    task automatic check_idle(input string tag);
        for (int id = 0; id < 2; id++) begin
            check({tag, "_ncs"}, id, int'(ncs[id]), 1);
            check({tag, "_sclk"}, id, int'(sclk[id]), 0);
            check({tag, "_mosi"}, id, int'(mosi[id]), 0);
            check({tag, "_nldac"}, id, int'(nldac[id]), 1);
            check({tag, "_busy"}, id, int'(busy[id]), 0);
            check({tag, "_done"}, id, int'(done[id]), 0);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!(quiet(0) && quiet(1)) && n < budget);
        if (!(quiet(0) && quiet(1))) begin
            n_cmp++; n_err++;
            $display("FAIL wait_quiet: still active after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic wait_seq0(input int budget);
        int n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (m_mode[0] != 2 && n < budget);
        if (m_mode[0] != 2) begin
            n_cmp++; n_err++;
            $display("FAIL wait_seq0: no sequence after %0d cycles, expected one", budget);
        end
    endtask

    task automatic pulse_req();
        @(posedge clock); #1 update_req = 1'b1;
        @(posedge clock); #1 update_req = 1'b0;
    endtask

    int d0_before, l0_before;

    initial begin
        for (int id = 0; id < 2; id++) begin
            m_seq[id] = 0; done_cnt[id] = 0; ldac_cnt[id] = 0; m_mode[id] = 0; m_sync[id] = 0;
            m_req[id] = 1'b1; m_sha[id] = 12'd0; m_shb[id] = 12'd0; m_left[id] = 0;
        end
        fork
            model(0); model(1); monitor(0); monitor(1);
        join_none

        // Reset state, then synchronised release: no capture on the first two edges.
        repeat (3) @(posedge clock);
        #1 check_idle("reset");
        nRST = 1'b1;
        @(posedge clock); #1 check("sync_edge1_busy", 0, int'(busy), 0);
        @(posedge clock); #1 check("sync_edge2_busy", 0, int'(busy), 0);
        @(posedge clock); #1 check("first_capture_busy", 0, int'(busy), 3);

        // All-zero inputs: exactly one sequence (0x3000 / 0xB000), then stays idle.
        wait_quiet(1000);
        repeat (200) @(posedge clock);
        #1;
        for (int id = 0; id < 2; id++) begin
            check("first_seq_count", id, done_cnt[id], 1);
            check("stays_idle_busy", id, int'(busy[id]), 0);
        end

        // Single channel change still sends both frames.
        AOUT1 = 12'hA5C;
        wait_quiet(1000);

        // Change B while frame A is in flight: old B goes out, then a second sequence.
        AOUT1 = 12'h3C7;
        d0_before = done_cnt[0];
        wait_seq0(100);
        repeat (10) @(posedge clock);
        #1 AOUT2 = 12'h123;
        wait_quiet(1000);
        check("mid_frame_change_seqs", 0, done_cnt[0] - d0_before, 2);

        // update_req with no change, then a second pulse while busy: two sequences total.
        d0_before = done_cnt[0];
        pulse_req();
        wait_seq0(100);
        repeat (20) @(posedge clock);
        pulse_req();
        wait_quiet(1000);
        check("update_req_seqs", 0, done_cnt[0] - d0_before, 2);

        // Reset in the 9th bit of frame B (dut0): immediate idle, no nLDAC, full rerun after.
        pulse_req();
        wait_seq0(100);
        repeat (103) @(posedge clock);
        #1 check("pre_abort_in_frame", 0, int'(ncs[0]), 0);
        l0_before = ldac_cnt[0];
        d0_before = done_cnt[0];
        nRST = 1'b0;
        #1 check_idle("abort");
        repeat (4) @(posedge clock);
        #1 check("abort_no_ldac", 0, ldac_cnt[0] - l0_before, 0);
        nRST = 1'b1;
        wait_quiet(1000);
        check("after_abort_seqs", 0, done_cnt[0] - d0_before, 1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #1;
            update_req = 1'b0;
            if ($urandom_range(0, 59) == 0) AOUT1 = 12'($urandom);
            if ($urandom_range(0, 59) == 0) AOUT2 = 12'($urandom);
            if ($urandom_range(0, 79) == 0) update_req = 1'b1;
        end
        @(posedge clock); #1 update_req = 1'b0;
        wait_quiet(3000);
        repeat (20) @(posedge clock);
        #1;
        for (int id = 0; id < 2; id++) begin
            check("done_count", id, done_cnt[id], m_seq[id]);
            check("ldac_count", id, ldac_cnt[id], m_seq[id]);
            check("queue_left", id, (id == 0) ? exp_q0.size() : exp_q1.size(), 0);
            check("final_busy", id, int'(busy[id]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
